// File: rtl/icache_ctrl_if.sv
// Fetch, cache-memory and memory-bus signals of the instruction-cache miss controller.
// The controller takes the master side; the fetch stage, cache memory and bus arbiter form the slave side.
interface icache_ctrl_if;
    logic [2:0]       fetch_valid;
    logic [2:0][31:0] fetch_addr;
    logic             flush;

    logic [2:0][63:0] icache_cachemem_data;
    logic [2:0]       icache_cachemem_valid;

    logic [3:0]       mem2proc_response;
    logic [3:0]       mem2proc_tag;
    logic [63:0]      mem2proc_data;

    logic [2:0][4:0]  icache_read_index;
    logic [2:0][7:0]  icache_read_tag;
    logic             icache_data_write_enable;
    logic [4:0]       icache_write_index;
    logic [7:0]       icache_write_tag;

    logic [1:0]       proc2mem_command;
    logic [31:0]      proc2mem_addr;

    logic [2:0][31:0] fetch_inst;
    logic [2:0]       fetch_hit;
    logic             mshr_full;

    modport master (
        input  fetch_valid, fetch_addr, flush,
        input  icache_cachemem_data, icache_cachemem_valid,
        input  mem2proc_response, mem2proc_tag, mem2proc_data,
        output icache_read_index, icache_read_tag,
        output icache_data_write_enable, icache_write_index, icache_write_tag,
        output proc2mem_command, proc2mem_addr,
        output fetch_inst, fetch_hit, mshr_full
    );

    modport slave (
        output fetch_valid, fetch_addr, flush,
        output icache_cachemem_data, icache_cachemem_valid,
        output mem2proc_response, mem2proc_tag, mem2proc_data,
        input  icache_read_index, icache_read_tag,
        input  icache_data_write_enable, icache_write_index, icache_write_tag,
        input  proc2mem_command, proc2mem_addr,
        input  fetch_inst, fetch_hit, mshr_full
    );
endinterface

// File: rtl/icache_ctrl.sv
// Three-lane I-cache lookup plus miss controller tracking outstanding BUS_LOADs by memory tag.
// Latency: hits and miss requests are combinational; a fill writes at its edge, hitting the next cycle.
// Backpressure: a rejected request (response 0) is re-evaluated each cycle; no issue while MSHRs are full.
module icache_ctrl #(
    parameter int NUM_MSHR = 4
) (
    input  logic          clock,
    input  logic          reset,
    icache_ctrl_if.master io
);

    typedef struct packed {
        logic        valid;
        logic [3:0]  mem_tag;
        logic [12:0] line;
    } mshr_t;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } bus_cmd_e;

    mshr_t mshr_q [NUM_MSHR];

    logic [2:0][12:0]    lane_line;
    logic [2:0]          lane_hit;
    logic [2:0]          lane_busy;

    logic [NUM_MSHR-1:0] fill_oh;
    logic [NUM_MSHR-1:0] free_oh;
    logic                fill_vld;
    logic [12:0]         fill_line;
    logic                free_vld;
    logic                all_vld;

    logic                cand_vld;
    logic [12:0]         cand_line;
    logic                issue_vld;
    logic                alloc_vld;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lane_line[i]            = io.fetch_addr[i][15:3];
            io.icache_read_index[i] = io.fetch_addr[i][7:3];
            io.icache_read_tag[i]   = io.fetch_addr[i][15:8];
            lane_hit[i]             = io.fetch_valid[i] & io.icache_cachemem_valid[i];
            io.fetch_inst[i]        = io.fetch_addr[i][2] ? io.icache_cachemem_data[i][63:32]
                                                          : io.icache_cachemem_data[i][31:0];
        end
        io.fetch_hit = lane_hit;
    end

    // Fill match and free-entry search; a filling entry stays valid, so it is never free this cycle.
    always_comb begin
        fill_vld  = 1'b0;
        fill_oh   = '0;
        fill_line = '0;
        free_vld  = 1'b0;
        free_oh   = '0;
        all_vld   = 1'b1;
        for (int e = 0; e < NUM_MSHR; e++) begin
            all_vld = all_vld & mshr_q[e].valid;
            if (!fill_vld && mshr_q[e].valid && (io.mem2proc_tag != 4'd0) &&
                (mshr_q[e].mem_tag == io.mem2proc_tag)) begin
                fill_vld   = 1'b1;
                fill_oh[e] = 1'b1;
                fill_line  = mshr_q[e].line;
            end
            if (!free_vld && !mshr_q[e].valid) begin
                free_vld   = 1'b1;
                free_oh[e] = 1'b1;
            end
        end
    end

    always_comb begin
        lane_busy = '0;
        for (int i = 0; i < 3; i++) begin
            for (int e = 0; e < NUM_MSHR; e++) begin
                if (mshr_q[e].valid && (mshr_q[e].line == lane_line[i])) begin
                    lane_busy[i] = 1'b1;
                end
            end
        end
    end

    // Lowest missing lane whose line is not already in flight; same-line lanes collapse naturally.
    always_comb begin
        cand_vld  = 1'b0;
        cand_line = '0;
        for (int i = 0; i < 3; i++) begin
            if (!cand_vld && io.fetch_valid[i] && !lane_hit[i] && !lane_busy[i]) begin
                cand_vld  = 1'b1;
                cand_line = lane_line[i];
            end
        end
    end

    always_comb begin
        issue_vld = cand_vld & ~io.flush & reset & free_vld;
        alloc_vld = issue_vld & (io.mem2proc_response != 4'd0);

        io.proc2mem_command = issue_vld ? BUS_LOAD : BUS_NONE;
        io.proc2mem_addr    = issue_vld ? {16'b0, cand_line, 3'b0} : 32'd0;

        io.icache_data_write_enable = reset & fill_vld;
        io.icache_write_index       = io.icache_data_write_enable ? fill_line[4:0]  : 5'd0;
        io.icache_write_tag         = io.icache_data_write_enable ? fill_line[12:5] : 8'd0;

        io.mshr_full = reset & all_vld;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int e = 0; e < NUM_MSHR; e++) begin
                mshr_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_MSHR; e++) begin
                if (fill_oh[e]) begin
                    mshr_q[e].valid <= 1'b0;
                end
                if (alloc_vld && free_oh[e]) begin
                    mshr_q[e] <= '{valid: 1'b1, mem_tag: io.mem2proc_response, line: cand_line};
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a 32-line cache-memory model and a scoreboard of expected bus requests.
module tb_icache_ctrl;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] exp_q [$];
    logic [63:0] d1, d2, d3, dz;

    logic [31:0] cm_vld;
    logic [7:0]  cm_tag  [32];
    logic [63:0] cm_data [32];

    icache_ctrl_if bus ();

    icache_ctrl #(.NUM_MSHR(4)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset) begin
            cm_vld <= '0;
        end else if (bus.icache_data_write_enable) begin
            cm_vld[bus.icache_write_index]  <= 1'b1;
            cm_tag[bus.icache_write_index]  <= bus.icache_write_tag;
            cm_data[bus.icache_write_index] <= bus.mem2proc_data;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bus.icache_cachemem_valid[i] = cm_vld[bus.icache_read_index[i]] &&
                                           (cm_tag[bus.icache_read_index[i]] == bus.icache_read_tag[i]);
            bus.icache_cachemem_data[i]  = cm_data[bus.icache_read_index[i]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    // Every accepted request must match the oldest expected address.
    always @(negedge clock) begin
        if (reset === 1'b1 && bus.proc2mem_command == 2'd1 && bus.mem2proc_response != 4'd0) begin
            if (exp_q.size() == 0) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL sb_unexpected observed=%0h expected=none", bus.proc2mem_addr);
                end
            end else begin
                chk("sb_addr", {32'd0, bus.proc2mem_addr}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        d1 = 64'hCAFEF00D_0BADC0DE;
        d2 = 64'h11112222_33334444;
        d3 = 64'h55556666_77778888;
        dz = 64'h0;
        reset = 1'b0;
        bus.fetch_valid = '0;
        bus.fetch_addr = '0;
        bus.flush = 1'b0;
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag = 4'd0;
        bus.mem2proc_data = dz;

        // Outputs held quiet during reset, even with a pending miss.
        next();
        bus.fetch_valid = 3'b001;
        bus.fetch_addr[0] = 32'h40;
        bus.mem2proc_response = 4'd3;
        settle();
        chk("rst_cmd", bus.proc2mem_command, 0);
        chk("rst_addr", bus.proc2mem_addr, 0);
        chk("rst_we", bus.icache_data_write_enable, 0);
        chk("rst_full", bus.mshr_full, 0);

        // Single miss, fill ten cycles later, hit afterwards.
        next();
        reset = 1'b1;
        exp_q.push_back(32'h40);
        settle();
        chk("t1_cmd", bus.proc2mem_command, 1);
        chk("t1_addr", bus.proc2mem_addr, 32'h40);
        chk("t1_miss", bus.fetch_hit, 3'b000);
        next();
        bus.mem2proc_response = 4'd0;
        settle();
        chk("t1_inflight", bus.proc2mem_command, 0);
        for (int k = 0; k < 9; k++) next();
        bus.mem2proc_tag = 4'd3;
        bus.mem2proc_data = d1;
        settle();
        chk("t1_we", bus.icache_data_write_enable, 1);
        chk("t1_widx", bus.icache_write_index, 8);
        chk("t1_wtag", bus.icache_write_tag, 0);
        chk("t1_nohit_yet", bus.fetch_hit, 3'b000);
        next();
        bus.mem2proc_tag = 4'd0;
        bus.mem2proc_data = dz;
        bus.fetch_valid = 3'b011;
        bus.fetch_addr[1] = 32'h44;
        settle();
        chk("t1_hit", bus.fetch_hit, 3'b011);
        chk("t1_inst_lo", bus.fetch_inst[0], {32'd0, d1[31:0]});
        chk("t1_inst_hi", bus.fetch_inst[1], {32'd0, d1[63:32]});
        chk("t1_hit_cmd", bus.proc2mem_command, 0);

        // Three lanes, two distinct lines: one request per cycle, duplicate suppressed.
        next();
        bus.fetch_valid = 3'b111;
        bus.fetch_addr[0] = 32'h100;
        bus.fetch_addr[1] = 32'h104;
        bus.fetch_addr[2] = 32'h200;
        bus.mem2proc_response = 4'd1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h200);
        settle();
        chk("t2_cmd0", bus.proc2mem_command, 1);
        chk("t2_addr0", bus.proc2mem_addr, 32'h100);
        next();
        bus.mem2proc_response = 4'd2;
        settle();
        chk("t2_addr1", bus.proc2mem_addr, 32'h200);
        next();
        bus.mem2proc_response = 4'd0;
        settle();
        chk("t2_dup", bus.proc2mem_command, 0);
        chk("t2_notfull", bus.mshr_full, 0);
        next();
        bus.fetch_valid = 3'b000;
        bus.mem2proc_tag = 4'd1;
        bus.mem2proc_data = d2;
        settle();
        chk("t2_fill1_idx", bus.icache_write_index, 0);
        chk("t2_fill1_tag", bus.icache_write_tag, 1);
        next();
        bus.mem2proc_tag = 4'd2;
        bus.mem2proc_data = d3;
        settle();
        chk("t2_fill2_we", bus.icache_data_write_enable, 1);
        chk("t2_fill2_tag", bus.icache_write_tag, 2);
        next();
        bus.mem2proc_tag = 4'd0;

        // Rejected three times, then accepted with tag 5.
        bus.fetch_valid = 3'b001;
        bus.fetch_addr[0] = 32'h300;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t3_hold_cmd", bus.proc2mem_command, 1);
            chk("t3_hold_addr", bus.proc2mem_addr, 32'h300);
            next();
        end
        bus.mem2proc_response = 4'd5;
        exp_q.push_back(32'h300);
        settle();
        chk("t3_accept_addr", bus.proc2mem_addr, 32'h300);
        next();
        bus.mem2proc_response = 4'd0;
        settle();
        chk("t3_inflight", bus.proc2mem_command, 0);
        next();
        bus.fetch_valid = 3'b000;
        bus.mem2proc_tag = 4'd5;
        settle();
        chk("t3_fill_we", bus.icache_data_write_enable, 1);
        chk("t3_fill_tag", bus.icache_write_tag, 3);
        next();
        bus.mem2proc_tag = 4'd0;
        settle();
        chk("t3_empty", bus.mshr_full, 0);

        // Fill all four entries, then a fifth miss waits for a freed entry.
        next();
        bus.fetch_valid = 3'b001;
        for (int k = 0; k < 4; k++) begin
            bus.fetch_addr[0] = 32'h1000 + 32'(8 * k);
            bus.mem2proc_response = 4'(k + 1);
            exp_q.push_back(32'h1000 + 32'(8 * k));
            settle();
            chk("t4_issue", bus.proc2mem_command, 1);
            next();
        end
        bus.fetch_addr[0] = 32'h1020;
        bus.mem2proc_response = 4'd6;
        settle();
        chk("t4_full", bus.mshr_full, 1);
        chk("t4_full_cmd", bus.proc2mem_command, 0);
        next();
        bus.mem2proc_tag = 4'd1;
        settle();
        chk("t4_fill_we", bus.icache_data_write_enable, 1);
        chk("t4_fill_idx", bus.icache_write_index, 0);
        chk("t4_fill_wtag", bus.icache_write_tag, 8'h10);
        chk("t4_fill_noissue", bus.proc2mem_command, 0);
        next();
        bus.mem2proc_tag = 4'd0;
        exp_q.push_back(32'h1020);
        settle();
        chk("t4_after_cmd", bus.proc2mem_command, 1);
        chk("t4_after_addr", bus.proc2mem_addr, 32'h1020);
        next();
        bus.mem2proc_response = 4'd0;
        settle();
        chk("t4_refull", bus.mshr_full, 1);

        // Bogus tag, draining fills, flush, then fill and issue together.
        next();
        bus.fetch_valid = 3'b000;
        bus.mem2proc_tag = 4'd9;
        settle();
        chk("t5_bogus_we", bus.icache_data_write_enable, 0);
        next();
        bus.mem2proc_tag = 4'd2;
        settle();
        chk("t5_fill2_idx", bus.icache_write_index, 1);
        next();
        bus.mem2proc_tag = 4'd3;
        settle();
        chk("t5_fill3_idx", bus.icache_write_index, 2);
        next();
        bus.mem2proc_tag = 4'd0;
        bus.fetch_valid = 3'b001;
        bus.fetch_addr[0] = 32'h2000;
        bus.flush = 1'b1;
        bus.mem2proc_response = 4'd7;
        settle();
        chk("t5_notfull", bus.mshr_full, 0);
        chk("t5_flush_cmd", bus.proc2mem_command, 0);
        next();
        bus.flush = 1'b0;
        bus.mem2proc_tag = 4'd4;
        exp_q.push_back(32'h2000);
        settle();
        chk("t5_both_cmd", bus.proc2mem_command, 1);
        chk("t5_both_we", bus.icache_data_write_enable, 1);
        chk("t5_both_idx", bus.icache_write_index, 3);
        next();
        bus.mem2proc_tag = 4'd0;
        bus.mem2proc_response = 4'd0;
        bus.fetch_valid = 3'b000;

        // Reset with tags 6 and 7 outstanding: their returns are ignored.
        next();
        reset = 1'b0;
        bus.fetch_valid = 3'b001;
        bus.fetch_addr[0] = 32'h3000;
        bus.mem2proc_response = 4'd8;
        bus.mem2proc_tag = 4'd6;
        settle();
        chk("t6_rst_we", bus.icache_data_write_enable, 0);
        chk("t6_rst_widx", bus.icache_write_index, 0);
        chk("t6_rst_cmd", bus.proc2mem_command, 0);
        chk("t6_rst_full", bus.mshr_full, 0);
        next();
        reset = 1'b1;
        bus.fetch_valid = 3'b000;
        bus.mem2proc_response = 4'd0;
        settle();
        chk("t6_tag6_ignored", bus.icache_data_write_enable, 0);
        next();
        bus.mem2proc_tag = 4'd7;
        settle();
        chk("t6_tag7_ignored", bus.icache_data_write_enable, 0);
        chk("t6_full", bus.mshr_full, 0);
        next();
        bus.mem2proc_tag = 4'd0;
        settle();

        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Miss controller and fetch front-end for the 32-line direct-mapped instruction cache memory: 64-bit blocks, 5-bit index, 8-bit tag, three read ports. Each cycle it looks up up to three fetch addresses and returns hit instructions. It issues BUS_LOAD requests for missing lines, tracks up to NUM_MSHR outstanding loads by memory tag, and writes returning blocks into the cache memory. It sits between the fetch stage, the cache memory and the memory bus arbiter.

## Interface
- NUM_MSHR, 4, number of outstanding-miss entries; 1..15

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- fetch_valid  in  [2:0]  lane i requests an instruction
- fetch_addr  in  [2:0][31:0]  byte address; bits [15:3] are the line address
- flush  in  1  squash: suppress miss issue this cycle
- icache_cachemem_data  in  [2:0][63:0]  block read per lane
- icache_cachemem_valid  in  [2:0]  valid and tag match per lane
- mem2proc_response  in  4  tag assigned to this cycle's request; 0 = rejected
- mem2proc_tag  in  4  tag of the block on mem2proc_data; 0 = none
- mem2proc_data  in  64  returning block; wired straight to the cache memory write data at top level
- icache_read_index  out  [2:0][4:0]  fetch_addr[i][7:3]
- icache_read_tag  out  [2:0][7:0]  fetch_addr[i][15:8]
- icache_data_write_enable  out  1  fill strobe
- icache_write_index  out  5  fill line index
- icache_write_tag  out  8  fill line tag
- proc2mem_command  out  2  0 = BUS_NONE, 1 = BUS_LOAD
- proc2mem_addr  out  32  {16'b0, line[12:0], 3'b0}
- fetch_inst  out  [2:0][31:0]  fetch_addr[i][2] ? data[63:32] : data[31:0]
- fetch_hit  out  [2:0]  fetch_valid[i] & icache_cachemem_valid[i]
- mshr_full  out  1  all MSHR entries valid

## Operation
- Lookup is purely combinational. The index and tag come from each lane's address, and a hit is the cache valid bit gated by fetch_valid.
- Each MSHR entry holds three fields: valid, mem_tag[3:0] and line[12:0].
- Miss candidate: the lowest-numbered lane with fetch_valid=1 and fetch_hit=0.
  - The candidate is dropped if its line matches any valid MSHR entry, including an entry filling this cycle.
  - If the lowest lane's line is in flight, the next lane is considered.
  - Lanes with the same line yield one request.
- Issue rules:
  - Issue only if a candidate exists, flush=0, reset=1 and a non-filling free entry exists.
  - When issuing, drive proc2mem_command=BUS_LOAD and set proc2mem_addr from the candidate line.
  - Otherwise drive BUS_NONE with address 0.
- Allocation: if mem2proc_response≠0 in the issue cycle, the lowest free entry captures {1, response, line} at the clock edge.
- Rejection: if mem2proc_response=0, nothing is allocated. The candidate is re-evaluated next cycle; no internal retry state is kept.
- Fill:
  - If mem2proc_tag≠0 and it equals the mem_tag of a valid entry, assert icache_data_write_enable the same cycle.
  - write_index is line[4:0] and write_tag is line[12:5].
  - The entry is cleared at the edge.
- A mem2proc_tag that matches no valid entry is ignored: no write.
- At most one fill per cycle, since the memory returns one tag.
- Flush blocks issue only. Outstanding entries still fill, because the data stays useful.
- mshr_full is a registered-state decode: 1 when all entries are valid.

## Timing
- Hit: zero-cycle; fetch_inst and fetch_hit are valid in the same cycle as fetch_addr.
- Miss to request: proc2mem_command is asserted in the same cycle as the miss.
- Fill to hit: write at the fill-cycle edge; fetch_hit=1 from the next cycle.
- Minimum miss-to-hit latency is therefore memory latency + 1 cycle.
- Entry freed by a fill is allocatable from the cycle after the fill, never in the fill cycle.
- Same cycle fill and issue: both proceed if another entry is free.
  - Fill and issue to the same line: no issue.
- With reset=0 at a clock edge: all entries are invalidated.
- Outputs while reset=0:
  - proc2mem_command=BUS_NONE, proc2mem_addr=0.
  - icache_data_write_enable=0, write index and tag 0.
  - mshr_full=0.
- Reset mid-miss: later returning tags match nothing and are ignored.
- Full: with mshr_full=1 and no fill this cycle, the command stays BUS_NONE.

## Test plan
- Reset, lane0 fetch 0x0040 (miss), response=3:
  - BUS_LOAD, addr 0x0040, same cycle.
  - Tag 3 returns 10 cycles later: write_enable=1, index 8, tag 0x00.
  - Next cycle fetch_hit[0]=1 and fetch_inst = data[31:0].
- Lanes 0/1/2 at 0x100, 0x104 and 0x200, all missing:
  - One request per cycle: 0x100, then 0x200.
  - The lane1 duplicate is never requested.
- response=0 for 3 cycles, then 5: BUS_LOAD is held with the same addr for 4 cycles, and one entry is allocated with tag 5.
- Fill 4 distinct lines (NUM_MSHR=4):
  - mshr_full=1 and a fifth miss is not issued.
  - In the fill cycle of tag 1 the fifth miss is still not issued; it is issued in the following cycle.
- Edge cases on bogus tags, flush and reset:
  - mem2proc_tag=9 with no entry holding tag 9: no write.
  - flush=1 during a miss: BUS_NONE that cycle.
  - reset=0 while 2 entries are outstanding: their returns are ignored and mshr_full=0.
